// File: rtl/pcs_sync_fsm_param_if.sv
// Bus bundle for pcs_sync_fsm_param: classifier-side code-group strobe in,
// synchronization status, SUDI and statistics out.
interface pcs_sync_fsm_param_if;
  // Handshake: cg_valid is a one-cycle strobe with no back-pressure; every
  // cycle it is high (with signal_detect high) one code group is consumed.
  // SUDI_valid is the matching one-cycle strobe on the output side.
  logic        cg_valid;
  logic [9:0]  rx_code_group;
  logic        rx_cg_invalid;
  logic        rx_cg_is_data;
  logic        signal_detect;

  logic        code_sync_status;
  logic        rx_even;
  logic [9:0]  SUDI;
  logic        SUDI_valid;
  logic [15:0] sync_loss_count;
  logic [15:0] bad_cg_count;
  // Debug view of the FSM: 0 LOSS_OF_SYNC, 1 COMMA_DETECT, 2 ACQUIRE_SYNC, 3 SYNC_ACQUIRED
  logic [1:0]  state_dbg;

  modport master (
    output cg_valid, rx_code_group, rx_cg_invalid, rx_cg_is_data, signal_detect,
    input  code_sync_status, rx_even, SUDI, SUDI_valid,
    input  sync_loss_count, bad_cg_count, state_dbg
  );

  modport slave (
    input  cg_valid, rx_code_group, rx_cg_invalid, rx_cg_is_data, signal_detect,
    output code_sync_status, rx_even, SUDI, SUDI_valid,
    output sync_loss_count, bad_cg_count, state_dbg
  );
endinterface

// File: rtl/pcs_sync_fsm_param.sv
// 1000BASE-X style code-group synchronization FSM with parametrised thresholds.
// Optional statistics counters are built when PCS_SYNC_STATS_EN is defined.
module pcs_sync_fsm_param #(
  parameter int COMMAS_TO_SYNC  = 3,
  parameter int BAD_TO_LOSE     = 4,
  parameter int GOOD_TO_RECOVER = 4
) (
  input logic                  Clk,
  input logic                  Reset,
  pcs_sync_fsm_param_if.slave  bus
);

  localparam int CW = $clog2(COMMAS_TO_SYNC + 1);
  localparam int BW = $clog2(BAD_TO_LOSE + 1);
  localparam int GW = $clog2(GOOD_TO_RECOVER + 1);

  localparam logic [CW-1:0] COMMA_TARGET = CW'(COMMAS_TO_SYNC);
  localparam logic [BW-1:0] BAD_LAST     = BW'(BAD_TO_LOSE - 1);
  localparam logic [GW-1:0] GOOD_LAST    = GW'(GOOD_TO_RECOVER - 1);

  typedef enum logic [1:0] {
    LOSS_OF_SYNC  = 2'd0,
    COMMA_DETECT  = 2'd1,
    ACQUIRE_SYNC  = 2'd2,
    SYNC_ACQUIRED = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_comma_cnt;
  logic [BW-1:0] r_bad_lvl;
  logic [GW-1:0] r_good_cnt;
  logic          r_rx_even;
  logic [9:0]    r_sudi;
  logic          r_sudi_valid;

  state_t        w_state_nxt;
  logic [CW-1:0] w_comma_cnt_nxt;
  logic [BW-1:0] w_bad_lvl_nxt;
  logic [GW-1:0] w_good_cnt_nxt;
  logic          w_rx_even_nxt;

  logic w_comma;
  logic w_cgbad;
  logic w_accept;

  assign w_comma  = (bus.rx_code_group[9:3] == 7'b0011111) ||
                    (bus.rx_code_group[9:3] == 7'b1100000);
  // A comma is only legal on an even position, i.e. when the previous group was odd.
  assign w_cgbad  = bus.rx_cg_invalid | (w_comma & r_rx_even);
  assign w_accept = bus.cg_valid & bus.signal_detect;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= LOSS_OF_SYNC;
      r_comma_cnt  <= '0;
      r_bad_lvl    <= '0;
      r_good_cnt   <= '0;
      r_rx_even    <= 1'b0;
      r_sudi       <= '0;
      r_sudi_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_comma_cnt  <= w_comma_cnt_nxt;
      r_bad_lvl    <= w_bad_lvl_nxt;
      r_good_cnt   <= w_good_cnt_nxt;
      r_rx_even    <= w_rx_even_nxt;
      r_sudi_valid <= w_accept;
      if (w_accept) begin
        r_sudi <= bus.rx_code_group;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_comma_cnt_nxt = r_comma_cnt;
    w_bad_lvl_nxt   = r_bad_lvl;
    w_good_cnt_nxt  = r_good_cnt;
    w_rx_even_nxt   = r_rx_even;

    if (!bus.signal_detect) begin
      w_state_nxt     = LOSS_OF_SYNC;
      w_comma_cnt_nxt = '0;
      w_bad_lvl_nxt   = '0;
      w_good_cnt_nxt  = '0;
    end else if (bus.cg_valid) begin
      w_rx_even_nxt = ~r_rx_even;
      case (r_state)
        LOSS_OF_SYNC: begin
          if (w_comma) begin
            w_state_nxt     = COMMA_DETECT;
            w_comma_cnt_nxt = CW'(1);
            w_rx_even_nxt   = 1'b1;
          end
        end
        COMMA_DETECT: begin
          // rx_even is always 1 here, so the default toggle lands on 0.
          if (bus.rx_cg_is_data && !bus.rx_cg_invalid) begin
            if (r_comma_cnt < COMMA_TARGET) begin
              w_state_nxt = ACQUIRE_SYNC;
            end else begin
              w_state_nxt    = SYNC_ACQUIRED;
              w_bad_lvl_nxt  = '0;
              w_good_cnt_nxt = '0;
            end
          end else begin
            w_state_nxt = LOSS_OF_SYNC;
          end
        end
        ACQUIRE_SYNC: begin
          if (w_cgbad) begin
            w_state_nxt = LOSS_OF_SYNC;
          end else if (w_comma) begin
            w_state_nxt     = COMMA_DETECT;
            w_comma_cnt_nxt = r_comma_cnt + CW'(1);
            w_rx_even_nxt   = 1'b1;
          end
        end
        SYNC_ACQUIRED: begin
          if (w_cgbad) begin
            if (r_bad_lvl == BAD_LAST) begin
              w_state_nxt    = LOSS_OF_SYNC;
              w_bad_lvl_nxt  = '0;
              w_good_cnt_nxt = '0;
            end else begin
              w_bad_lvl_nxt  = r_bad_lvl + BW'(1);
              w_good_cnt_nxt = '0;
            end
          end else if (r_bad_lvl != '0) begin
            if (r_good_cnt == GOOD_LAST) begin
              w_bad_lvl_nxt  = r_bad_lvl - BW'(1);
              w_good_cnt_nxt = '0;
            end else begin
              w_good_cnt_nxt = r_good_cnt + GW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = LOSS_OF_SYNC;
        end
      endcase
    end
  end

  always_comb begin
    bus.code_sync_status = (r_state == SYNC_ACQUIRED);
    bus.rx_even          = r_rx_even;
    bus.SUDI             = r_sudi;
    bus.SUDI_valid       = r_sudi_valid;
    bus.state_dbg        = r_state;
  end

`ifdef PCS_SYNC_STATS_EN
  logic [15:0] r_sync_loss_count;
  logic [15:0] r_bad_cg_count;
  logic        w_loss_evt;
  logic        w_bad_evt;

  assign w_loss_evt = (r_state == SYNC_ACQUIRED) && (w_state_nxt == LOSS_OF_SYNC);
  assign w_bad_evt  = w_accept && (r_state == SYNC_ACQUIRED) && w_cgbad;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync_loss_count <= '0;
      r_bad_cg_count    <= '0;
    end else begin
      if (w_loss_evt && (r_sync_loss_count != 16'hFFFF)) begin
        r_sync_loss_count <= r_sync_loss_count + 16'd1;
      end
      if (w_bad_evt && (r_bad_cg_count != 16'hFFFF)) begin
        r_bad_cg_count <= r_bad_cg_count + 16'd1;
      end
    end
  end

  assign bus.sync_loss_count = r_sync_loss_count;
  assign bus.bad_cg_count    = r_bad_cg_count;
`else
  assign bus.sync_loss_count = 16'd0;
  assign bus.bad_cg_count    = 16'd0;
`endif

endmodule

// File: tb/tb_pcs_sync_fsm_param.sv
// Bench for pcs_sync_fsm_param: directed scenarios plus biased random traffic
// compared every cycle against a behavioural model of the sync rules.
module tb_pcs_sync_fsm_param;

  localparam int C = 3;
  localparam int B = 4;
  localparam int G = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  pcs_sync_fsm_param_if bus();

  pcs_sync_fsm_param #(
    .COMMAS_TO_SYNC (C),
    .BAD_TO_LOSE    (B),
    .GOOD_TO_RECOVER(G)
  ) u_dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: hunting (commas==0), waiting for the /D/ after a comma, or synced.
  bit         m_synced;
  bit         m_expect_data;
  int         m_commas;
  int         m_bad_lvl;
  int         m_good;
  bit         m_even;
  logic [9:0] m_sudi;
  bit         m_sudi_v;
  int         m_loss;
  int         m_badcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_comma(input logic [9:0] d);
    return (d[9:3] == 7'b0011111) || (d[9:3] == 7'b1100000);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] d;
    d = 10'($urandom_range(0, 1023));
    if (is_comma(d)) d[9] = ~d[9];
    return d;
  endfunction

  function automatic logic [9:0] rand_comma();
    return ($urandom_range(0, 1) != 0) ? 10'h0FA : 10'h305;
  endfunction

  task automatic model_step(input bit rst, input bit sd, input bit v,
                            input logic [9:0] cg, input bit inv, input bit dat);
    bit cm, bad;
    if (rst) begin
      m_synced = 0; m_expect_data = 0; m_commas = 0; m_bad_lvl = 0; m_good = 0;
      m_even = 0; m_sudi = '0; m_sudi_v = 0; m_loss = 0; m_badcnt = 0;
    end else if (!sd) begin
      if (m_synced && m_loss < 65535) m_loss++;
      m_synced = 0; m_expect_data = 0; m_commas = 0; m_bad_lvl = 0; m_good = 0;
      m_sudi_v = 0;
    end else if (!v) begin
      m_sudi_v = 0;
    end else begin
      cm = is_comma(cg);
      bad = inv | (cm & m_even);
      m_sudi = cg;
      m_sudi_v = 1;
      if (m_synced) begin
        m_even = !m_even;
        if (bad) begin
          if (m_badcnt < 65535) m_badcnt++;
          if (m_bad_lvl + 1 >= B) begin
            m_synced = 0; m_commas = 0; m_bad_lvl = 0; m_good = 0;
            if (m_loss < 65535) m_loss++;
          end else begin
            m_bad_lvl++; m_good = 0;
          end
        end else if (m_bad_lvl > 0) begin
          m_good++;
          if (m_good == G) begin m_bad_lvl--; m_good = 0; end
        end
      end else if (m_expect_data) begin
        m_expect_data = 0;
        m_even = 0;
        if (dat && !inv) begin
          if (m_commas >= C) begin m_synced = 1; m_bad_lvl = 0; m_good = 0; end
        end else begin
          m_commas = 0;
        end
      end else if (m_commas > 0) begin
        if (bad) begin
          m_commas = 0; m_even = !m_even;
        end else if (cm) begin
          m_commas++; m_expect_data = 1; m_even = 1;
        end else begin
          m_even = !m_even;
        end
      end else begin
        if (cm) begin m_commas = 1; m_expect_data = 1; m_even = 1; end
        else m_even = !m_even;
      end
    end
  endtask

  task automatic compare_all();
    check("sync_status", bus.code_sync_status, m_synced);
    check("rx_even", bus.rx_even, m_even);
    check("sudi_valid", bus.SUDI_valid, m_sudi_v);
    check("sudi", bus.SUDI, m_sudi);
`ifdef PCS_SYNC_STATS_EN
    check("sync_loss_count", bus.sync_loss_count, 32'(m_loss));
    check("bad_cg_count", bus.bad_cg_count, 32'(m_badcnt));
`else
    check("sync_loss_count", bus.sync_loss_count, 32'd0);
    check("bad_cg_count", bus.bad_cg_count, 32'd0);
`endif
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input bit rst, input bit sd, input bit v,
                       input logic [9:0] cg, input bit inv, input bit dat);
    @(negedge Clk);
    Reset = rst;
    bus.signal_detect = sd;
    bus.cg_valid = v;
    bus.rx_code_group = cg;
    bus.rx_cg_invalid = inv;
    bus.rx_cg_is_data = dat;
    model_step(rst, sd, v, cg, inv, dat);
    @(posedge Clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    cycle(1, 1, 0, rand_data(), 0, 0);
  endtask

  task automatic send_data(input int gap);
    cycle(0, 1, 1, rand_data(), 0, 1);
    repeat (gap) cycle(0, 1, 0, rand_data(), 0, 0);
  endtask

  task automatic send_comma(input logic [9:0] cg, input int gap);
    cycle(0, 1, 1, cg, 0, 0);
    repeat (gap) cycle(0, 1, 0, rand_data(), 0, 0);
  endtask

  task automatic send_invalid();
    cycle(0, 1, 1, rand_data(), 1, 0);
  endtask

  // Three commas on even positions, each followed by /D/.
  task automatic acquire(input bit gaps);
    send_comma(10'h0FA, gaps ? $urandom_range(1, 3) : 0);
    send_data(gaps ? $urandom_range(0, 2) : 0);
    send_data(gaps ? $urandom_range(0, 2) : 0);
    send_data(gaps ? $urandom_range(0, 2) : 0);
    send_comma(10'h305, gaps ? $urandom_range(0, 2) : 0);
    send_data(gaps ? $urandom_range(0, 2) : 0);
    send_comma(10'h0FA, gaps ? $urandom_range(0, 2) : 0);
    check("acq_not_early", bus.code_sync_status, 1'b0);
    cycle(0, 1, 1, 10'h2AA, 0, 1);
    check("acq_synced", bus.code_sync_status, 1'b1);
    check("acq_sudi", bus.SUDI, 10'h2AA);
  endtask

  initial begin
    Reset = 1'b1;
    bus.cg_valid = 1'b0;
    bus.rx_code_group = '0;
    bus.rx_cg_invalid = 1'b0;
    bus.rx_cg_is_data = 1'b0;
    bus.signal_detect = 1'b1;

    do_reset();
    do_reset();
    check("rst_state", bus.state_dbg, 2'd0);
    check("rst_status", bus.code_sync_status, 1'b0);

    // Gap-free acquisition followed by four invalids
    acquire(0);
    repeat (3) send_invalid();
    check("three_bad_still_sync", bus.code_sync_status, 1'b1);
    send_invalid();
    check("four_bad_lost", bus.code_sync_status, 1'b0);
`ifdef PCS_SYNC_STATS_EN
    check("loss_count_one", bus.sync_loss_count, 16'd1);
    check("bad_count_four", bus.bad_cg_count, 16'd4);
`endif

    // Recovery of one bad level by four good groups
    do_reset();
    acquire(0);
    send_invalid();
    repeat (4) send_data(0);
    repeat (3) send_invalid();
    check("recover_holds_sync", bus.code_sync_status, 1'b1);
    send_invalid();
    check("recover_then_lost", bus.code_sync_status, 1'b0);

    // Comma at odd position during ACQUIRE_SYNC
    do_reset();
    send_comma(10'h0FA, 0);
    send_data(0);
    send_data(0);
    send_comma(10'h305, 0);
    check("odd_comma_loss", bus.state_dbg, 2'd0);
    send_data(0);
    check("odd_comma_no_sync", bus.code_sync_status, 1'b0);

    // signal_detect dropped for one idle cycle
    do_reset();
    acquire(0);
    cycle(0, 0, 0, rand_data(), 0, 0);
    check("sigdet_drop", bus.code_sync_status, 1'b0);
    check("sigdet_state", bus.state_dbg, 2'd0);

    // Acquisition with cg_valid gaps
    do_reset();
    acquire(1);

    // Reset while synced with a group in flight
    cycle(1, 1, 1, 10'h0FA, 0, 0);
    check("rst_mid_status", bus.code_sync_status, 1'b0);
    check("rst_mid_even", bus.rx_even, 1'b0);
    check("rst_mid_valid", bus.SUDI_valid, 1'b0);
    check("rst_mid_state", bus.state_dbg, 2'd0);

    // Biased random traffic: commas steered toward even slots so sync is reached often
    for (int i = 0; i < 4000; i++) begin
      int r, p;
      bit rst, sd, v;
      r = $urandom_range(0, 299);
      rst = (r == 0);
      sd = !(r == 1 || r == 2);
      v = ($urandom_range(0, 7) != 0);
      p = $urandom_range(0, 99);
      if (p < 5)
        cycle(rst, sd, v, rand_data(), 1, 0);
      else if (p < 8)
        cycle(rst, sd, v, rand_comma(), 0, 0);
      else if (!m_even && !m_expect_data && p < 45)
        cycle(rst, sd, v, rand_comma(), 0, 0);
      else
        cycle(rst, sd, v, rand_data(), 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
